// File: rtl/patch_engine.sv
// Multi-channel ROM patch engine. It has a shadow bank with atomic commit, masked address
// match, compare-mode (deferred) patches, a holdoff gate and saturating hit counters.
module patch_engine #(
    parameter int NUM_CH      = 16,
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 8,
    parameter int CNT_W       = 16,
    parameter int HOLDOFF_CYC = 96000000,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] SNES_ADDR,
    input  logic [DATA_W-1:0] SNES_DATA_IN,
    input  logic              SNES_romdata_valid,
    input  logic              SNES_cycle_start,
    input  logic              SNES_cycle_end,
    input  logic              SNES_reset_strobe,
    input  logic              pgm_we,
    input  logic [CH_W-1:0]   pgm_ch,
    input  logic [1:0]        pgm_field,
    input  logic [31:0]       pgm_in,
    input  logic              pgm_commit,
    output logic              commit_done,
    input  logic [CH_W-1:0]   stat_ch,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  stat_hits,
    output logic [DATA_W-1:0] data_out,
    output logic              cheat_hit
);
    localparam int HO_W = $clog2(HOLDOFF_CYC + 1);

    logic [ADDR_W-1:0] sh_addr [NUM_CH];
    logic [ADDR_W-1:0] sh_mask [NUM_CH];
    logic [DATA_W-1:0] sh_data [NUM_CH];
    logic [DATA_W-1:0] sh_cmp  [NUM_CH];
    logic [NUM_CH-1:0] sh_cmode, sh_en;
    logic [ADDR_W-1:0] nx_addr [NUM_CH];
    logic [ADDR_W-1:0] nx_mask [NUM_CH];
    logic [DATA_W-1:0] nx_data [NUM_CH];
    logic [DATA_W-1:0] nx_cmp  [NUM_CH];
    logic [NUM_CH-1:0] nx_cmode, nx_en;
    logic [ADDR_W-1:0] ac_addr [NUM_CH];
    logic [ADDR_W-1:0] ac_mask [NUM_CH];
    logic [DATA_W-1:0] ac_data [NUM_CH];
    logic [DATA_W-1:0] ac_cmp  [NUM_CH];
    logic [NUM_CH-1:0] ac_cmode, ac_en;
    logic [CNT_W-1:0]  cnt [NUM_CH];

    logic              glob_en, holdoff_en, busy, pend, defer, hit;
    logic [HO_W-1:0]   holdoff;
    logic [NUM_CH-1:0] cm0_r, cm1_r;
    logic [CH_W-1:0]   win;

    logic [NUM_CH-1:0] m_now, cm0, cm1, below_u, eq, cand;
    logic [CH_W-1:0]   u_idx, c_idx;
    logic              defer_now, apply;
    logic              unused_pgm;

    assign unused_pgm = ^pgm_in;

    function automatic logic [CH_W-1:0] lowest(input logic [NUM_CH-1:0] v);
        lowest = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (v[i]) lowest = CH_W'(i);
    endfunction

    // Shadow contents after this clk's write; a commit in the same clk copies these.
    always_comb begin
        nx_cmode = sh_cmode;
        nx_en    = sh_en;
        for (int i = 0; i < NUM_CH; i++) begin
            nx_addr[i] = sh_addr[i];
            nx_mask[i] = sh_mask[i];
            nx_data[i] = sh_data[i];
            nx_cmp[i]  = sh_cmp[i];
            if (pgm_we && pgm_ch == CH_W'(i)) begin
                case (pgm_field)
                    2'd0: nx_addr[i] = pgm_in[ADDR_W-1:0];
                    2'd1: nx_mask[i] = pgm_in[ADDR_W-1:0];
                    2'd2: begin
                        nx_data[i]  = pgm_in[DATA_W-1:0];
                        nx_cmp[i]   = pgm_in[12+DATA_W-1:12];
                        nx_cmode[i] = pgm_in[30];
                        nx_en[i]    = pgm_in[31];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            m_now[i] = ac_en[i] && (((SNES_ADDR ^ ac_addr[i]) & ~ac_mask[i]) == '0);
            eq[i]    = (SNES_DATA_IN == ac_cmp[i]);
        end
    end

    // Compare-mode matches below the lowest unconditional match force a deferral.
    assign cm0       = m_now & ~ac_cmode;
    assign cm1       = m_now & ac_cmode;
    assign below_u   = ~cm0 & (cm0 - NUM_CH'(1));
    assign defer_now = |(cm1 & below_u);
    assign u_idx     = lowest(cm0);
    assign cand      = cm0_r | (cm1_r & eq);
    assign c_idx     = lowest(cand);
    assign apply     = pend && !busy && !SNES_cycle_start;

    assign cheat_hit = hit && glob_en && (holdoff == '0);
    assign stat_hits = cnt[stat_ch];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                sh_addr[i] <= '0; sh_mask[i] <= '0; sh_data[i] <= '0; sh_cmp[i] <= '0;
                ac_addr[i] <= '0; ac_mask[i] <= '0; ac_data[i] <= '0; ac_cmp[i] <= '0;
                cnt[i]     <= '0;
            end
            sh_cmode <= '0; sh_en <= '0; ac_cmode <= '0; ac_en <= '0;
            glob_en <= 1'b0; holdoff_en <= 1'b0; holdoff <= '0;
            busy <= 1'b0; pend <= 1'b0; defer <= 1'b0; hit <= 1'b0;
            cm0_r <= '0; cm1_r <= '0; win <= '0;
            data_out <= '0; commit_done <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                sh_addr[i] <= nx_addr[i]; sh_mask[i] <= nx_mask[i];
                sh_data[i] <= nx_data[i]; sh_cmp[i]  <= nx_cmp[i];
                if (apply) begin
                    ac_addr[i] <= nx_addr[i]; ac_mask[i] <= nx_mask[i];
                    ac_data[i] <= nx_data[i]; ac_cmp[i]  <= nx_cmp[i];
                end
                if (stat_clr && stat_ch == CH_W'(i))
                    cnt[i] <= '0;
                else if (SNES_cycle_end && cheat_hit && win == CH_W'(i) && cnt[i] != '1)
                    cnt[i] <= cnt[i] + CNT_W'(1);
            end
            sh_cmode <= nx_cmode;
            sh_en    <= nx_en;
            if (apply) begin
                ac_cmode <= nx_cmode;
                ac_en    <= nx_en;
            end
            commit_done <= apply;
            pend        <= apply ? 1'b0 : (pend || pgm_commit);

            if (pgm_we && pgm_field == 2'd3) begin
                glob_en    <= pgm_in[0];
                holdoff_en <= pgm_in[1];
            end
            if (SNES_reset_strobe && holdoff_en)
                holdoff <= HO_W'(HOLDOFF_CYC);
            else if (holdoff != '0)
                holdoff <= holdoff - HO_W'(1);

            if (SNES_reset_strobe || (SNES_cycle_end && !SNES_cycle_start)) begin
                busy <= 1'b0; defer <= 1'b0; hit <= 1'b0; data_out <= '0;
            end else if (SNES_cycle_start) begin
                busy     <= 1'b1;
                cm0_r    <= cm0;
                cm1_r    <= cm1;
                defer    <= defer_now;
                hit      <= !defer_now && (cm0 != '0);
                win      <= u_idx;
                data_out <= (!defer_now && cm0 != '0) ? ac_data[u_idx] : '0;
            end else if (defer && SNES_romdata_valid) begin
                defer    <= 1'b0;
                hit      <= (cand != '0);
                win      <= c_idx;
                data_out <= (cand != '0) ? ac_data[c_idx] : '0;
            end
        end
    end
endmodule

// File: tb/tb_patch_engine.sv
// Self-checking bench for patch_engine: directed scenarios plus randomized bus cycles
// compared against a channel-scan reference model.
module tb_patch_engine;
    logic        clk = 0, rst = 1;
    logic [23:0] SNES_ADDR = 0;
    logic [7:0]  SNES_DATA_IN = 0;
    logic        SNES_romdata_valid = 0, SNES_cycle_start = 0, SNES_cycle_end = 0;
    logic        SNES_reset_strobe = 0;
    logic        pgm_we = 0, pgm_commit = 0, stat_clr = 0;
    logic [2:0]  pgm_ch = 0, stat_ch = 0;
    logic [1:0]  pgm_field = 0;
    logic [31:0] pgm_in = 0;
    logic        commit_done, cheat_hit;
    logic [1:0]  stat_hits;
    logic [7:0]  data_out;

    patch_engine #(.NUM_CH(8), .ADDR_W(24), .DATA_W(8), .CNT_W(2), .HOLDOFF_CYC(20)) dut (
        .clk(clk), .rst(rst), .SNES_ADDR(SNES_ADDR), .SNES_DATA_IN(SNES_DATA_IN),
        .SNES_romdata_valid(SNES_romdata_valid), .SNES_cycle_start(SNES_cycle_start),
        .SNES_cycle_end(SNES_cycle_end), .SNES_reset_strobe(SNES_reset_strobe),
        .pgm_we(pgm_we), .pgm_ch(pgm_ch), .pgm_field(pgm_field), .pgm_in(pgm_in),
        .pgm_commit(pgm_commit), .commit_done(commit_done), .stat_ch(stat_ch),
        .stat_clr(stat_clr), .stat_hits(stat_hits), .data_out(data_out), .cheat_hit(cheat_hit));

    always #5 clk = ~clk;

    typedef struct { logic [23:0] a, mk; logic [7:0] d, c; bit cm, en; } ch_t;
    ch_t m_sh[8], m_ac[8];
    int  m_cnt[8];
    bit  m_glob, m_hoen;
    int  tb_ho;
    int  n_chk = 0, n_fail = 0;

    // Holdoff reference: cycles remaining after each clk
    always @(posedge clk or posedge rst)
        if (rst) tb_ho = 0;
        else if (SNES_reset_strobe && m_hoen) tb_ho = 20;
        else if (tb_ho > 0) tb_ho = tb_ho - 1;

    task automatic tick(); @(posedge clk); #1; endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_sh[i] = '{0, 0, 0, 0, 0, 0}; m_ac[i] = m_sh[i]; m_cnt[i] = 0;
        end
        m_glob = 0; m_hoen = 0;
    endtask

    // Scan channels in priority order; a compare-mode match blocks lower priorities
    // until ROM data is known.
    function automatic void resolve(input logic [23:0] addr, input bit post,
                                    input logic [7:0] rom, output bit hit, output int win);
        hit = 0; win = 0;
        for (int i = 0; i < 8; i++) begin
            if (m_ac[i].en && ((addr ^ m_ac[i].a) & ~m_ac[i].mk) == 24'h0) begin
                if (!m_ac[i].cm) begin hit = 1; win = i; return; end
                if (!post) return;
                if (rom == m_ac[i].c) begin hit = 1; win = i; return; end
            end
        end
    endfunction

    task automatic pgm(input int ch, input int field, input logic [31:0] v);
        pgm_we = 1; pgm_ch = 3'(ch); pgm_field = 2'(field); pgm_in = v;
        tick();
        pgm_we = 0;
        case (field)
            0: m_sh[ch].a = v[23:0];
            1: m_sh[ch].mk = v[23:0];
            2: begin m_sh[ch].d = v[7:0]; m_sh[ch].c = v[19:12];
                     m_sh[ch].cm = v[30]; m_sh[ch].en = v[31]; end
            default: begin m_glob = v[0]; m_hoen = v[1]; end
        endcase
    endtask

    task automatic set_ch(input int ch, input logic [23:0] a, input logic [23:0] mk,
                          input logic [7:0] d, input logic [7:0] c, input bit cm, input bit en);
        logic [31:0] v;
        v = 0; v[7:0] = d; v[19:12] = c; v[30] = cm; v[31] = en;
        pgm(ch, 0, {8'h0, a});
        pgm(ch, 1, {8'h0, mk});
        pgm(ch, 2, v);
    endtask

    task automatic commit();
        bit got;
        pgm_commit = 1; tick(); pgm_commit = 0;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            tick();
            if (commit_done) got = 1;
        end
        chk("commit_done_seen", got, 1);
        for (int i = 0; i < 8; i++) m_ac[i] = m_sh[i];
    endtask

    task automatic bus_cycle(input logic [23:0] addr, input logic [7:0] rom,
                             input bit clr, input string tag);
        bit h, g; int w;
        SNES_ADDR = addr; SNES_cycle_start = 1; tick(); SNES_cycle_start = 0;
        resolve(addr, 0, rom, h, w); g = h && m_glob && tb_ho == 0;
        chk({tag, "_pre_hit"}, cheat_hit, g);
        if (g) chk({tag, "_pre_data"}, data_out, m_ac[w].d);
        tick();
        SNES_DATA_IN = rom; SNES_romdata_valid = 1; tick(); SNES_romdata_valid = 0;
        resolve(addr, 1, rom, h, w); g = h && m_glob && tb_ho == 0;
        chk({tag, "_post_hit"}, cheat_hit, g);
        if (g) chk({tag, "_post_data"}, data_out, m_ac[w].d);
        SNES_cycle_end = 1; stat_clr = clr; tick(); SNES_cycle_end = 0; stat_clr = 0;
        if (g && m_cnt[w] < 3) m_cnt[w]++;
        if (clr) m_cnt[stat_ch] = 0;
        chk({tag, "_end_hit"}, cheat_hit, 0);
        chk({tag, "_end_data"}, data_out, 0);
        chk({tag, "_cnt"}, stat_hits, m_cnt[stat_ch]);
    endtask

    initial begin
        model_reset();
        tick(); tick();
        chk("rst_hit", cheat_hit, 0);
        chk("rst_data", data_out, 0);
        rst = 0;
        tick();
        chk("post_rst_hit", cheat_hit, 0);
        chk("post_rst_commit_done", commit_done, 0);
        chk("post_rst_cnt", stat_hits, 0);

        // Unconditional patch
        set_ch(3, 24'h00FFEA, 0, 8'h5C, 8'h00, 0, 1);
        commit();
        tick();
        chk("commit_pulse_width", commit_done, 0);
        pgm(0, 3, 32'h1);
        bus_cycle(24'h00FFEA, 8'h00, 0, "t1");
        bus_cycle(24'h00FFEB, 8'h00, 0, "t1_miss");

        // Compare-mode patch
        set_ch(0, 24'h808000, 24'h00000F, 8'hEA, 8'hA9, 1, 1);
        commit();
        bus_cycle(24'h808007, 8'hA9, 0, "t2_eq");
        bus_cycle(24'h808007, 8'hAD, 0, "t2_ne");

        // Priority between two unconditional channels
        set_ch(1, 24'h7E0010, 0, 8'h11, 8'h00, 0, 1);
        set_ch(5, 24'h7E0010, 0, 8'h55, 8'h00, 0, 1);
        commit();
        bus_cycle(24'h7E0010, 8'h00, 0, "t3_prio");
        set_ch(1, 24'h7E0010, 0, 8'h11, 8'h00, 0, 0);
        commit();
        bus_cycle(24'h7E0010, 8'h00, 0, "t3_dis");

        // Commit requested mid-cycle must wait for cycle end
        set_ch(2, 24'h123456, 0, 8'h22, 8'h00, 0, 1);
        commit();
        set_ch(2, 24'h123456, 0, 8'h2A, 8'h00, 0, 1);
        stat_ch = 2;
        SNES_ADDR = 24'h123456; SNES_cycle_start = 1; tick(); SNES_cycle_start = 0;
        chk("t4_hit", cheat_hit, 1);
        chk("t4_data", data_out, 8'h22);
        pgm_commit = 1; tick(); pgm_commit = 0;
        chk("t4_hold_data", data_out, 8'h22);
        chk("t4_no_commit", commit_done, 0);
        tick(); tick();
        chk("t4_hold_data2", data_out, 8'h22);
        chk("t4_no_commit2", commit_done, 0);
        SNES_cycle_end = 1; tick(); SNES_cycle_end = 0;
        m_cnt[2]++;
        chk("t4_end_hit", cheat_hit, 0);
        chk("t4_end_commit", commit_done, 0);
        tick();
        chk("t4_commit_after", commit_done, 1);
        for (int i = 0; i < 8; i++) m_ac[i] = m_sh[i];
        tick();
        chk("t4_commit_once", commit_done, 0);
        bus_cycle(24'h123456, 8'h00, 0, "t4_new");

        // Saturating counter and clear-wins
        set_ch(4, 24'h654321, 0, 8'h44, 8'h00, 0, 1);
        commit();
        stat_ch = 4;
        for (int k = 0; k < 5; k++) bus_cycle(24'h654321, 8'h00, 0, "t5_inc");
        chk("t5_sat", stat_hits, 3);
        bus_cycle(24'h654321, 8'h00, 1, "t5_clr");
        chk("t5_clr_zero", stat_hits, 0);

        // Global enable off
        pgm(0, 3, 32'h0);
        bus_cycle(24'h654321, 8'h00, 0, "glob_off");

        // Holdoff after SNES reset
        pgm(0, 3, 32'h3);
        SNES_reset_strobe = 1; tick(); SNES_reset_strobe = 0;
        chk("t6_ho_active", cheat_hit, 0);
        for (int k = 0; k < 8; k++) bus_cycle(24'h00FFEA, 8'h00, 0, "t6_ho");
        chk("t6_ho_expired", tb_ho, 0);

        // Randomized channels and bus traffic
        begin
            logic [23:0] pool[3], mks[4];
            logic [7:0]  cmps[3];
            pool = '{24'h400000, 24'h400100, 24'h401000};
            mks  = '{24'h0, 24'hF, 24'hFF, 24'h100};
            cmps = '{8'hA0, 8'hA1, 8'hA2};
            for (int i = 0; i < 8; i++)
                set_ch(i, pool[$urandom_range(2)] | 24'($urandom_range(15)),
                       mks[$urandom_range(3)], 8'($urandom), cmps[$urandom_range(1)],
                       1'($urandom_range(1)), $urandom_range(3) != 0);
            commit();
            for (int k = 0; k < 40; k++) begin
                stat_ch = 3'($urandom_range(7));
                bus_cycle(pool[$urandom_range(2)] | 24'($urandom_range(255)),
                          cmps[$urandom_range(2)], 0, "rnd");
            end
        end

        // Async reset mid-hit
        set_ch(6, 24'h0ABCDE, 0, 8'h66, 8'h00, 0, 1);
        commit();
        SNES_ADDR = 24'h0ABCDE; SNES_cycle_start = 1; tick(); SNES_cycle_start = 0;
        chk("t6_rst_prehit", cheat_hit, 1);
        #2 rst = 1; #1;
        chk("t6_rst_hit", cheat_hit, 0);
        chk("t6_rst_data", data_out, 0);
        model_reset();
        for (int i = 0; i < 8; i++) begin
            stat_ch = 3'(i); #1;
            chk("t6_rst_cnt", stat_hits, 0);
        end
        tick();
        rst = 0;
        tick();
        bus_cycle(24'h0ABCDE, 8'h00, 0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
